// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; one transaction in flight; MEM_ARB_RR_EN selects round-robin arbitration.
// Latency: request sampled at N, mem_req at N+1, rvalid earliest N+2; gnt/rvalid pass through combinationally from memory.
// Backpressure: the request is held in REQ until mem_gnt_ip; a watchdog aborts RESP after TIMEOUT_CYCLES.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_req_ip,
  input  logic [31:0] instr_addr_ip,
  output logic        instr_gnt_op,
  output logic        instr_rvalid_op,
  output logic [31:0] instr_rdata_op,
  input  logic        data_req_ip,
  input  logic [31:0] data_addr_ip,
  input  logic        data_we_ip,
  input  logic [3:0]  data_be_ip,
  input  logic [31:0] data_wdata_ip,
  output logic        data_gnt_op,
  output logic        data_rvalid_op,
  output logic [31:0] data_rdata_op,
  output logic        mem_req_op,
  output logic [31:0] mem_addr_op,
  output logic        mem_we_op,
  output logic [3:0]  mem_be_op,
  output logic [31:0] mem_wdata_op,
  input  logic        mem_gnt_ip,
  input  logic        mem_rvalid_ip,
  input  logic [31:0] mem_rdata_ip,
  output logic        timeout_err_op
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state_q, state_d;
  logic           owner_q, owner_d;  // 1 = data requester
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           we_q, we_d;
  logic [3:0]     be_q, be_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
  logic           pick_data;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // On a tie, the requester that did not win the last grant goes first.
  always_comb pick_data = data_req_ip && (!instr_req_ip || !last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == REQ && mem_gnt_ip) last_d = owner_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= 1'b0;
    else        last_q <= last_d;
  end
`else
  always_comb pick_data = data_req_ip;
`endif

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    we_d            = we_q;
    be_d            = be_q;
    wdog_d          = wdog_q;
    err_d           = err_q;
    mem_req_op      = 1'b0;
    mem_addr_op     = '0;
    mem_we_op       = 1'b0;
    mem_be_op       = '0;
    mem_wdata_op    = '0;
    instr_gnt_op    = 1'b0;
    data_gnt_op     = 1'b0;
    instr_rvalid_op = 1'b0;
    data_rvalid_op  = 1'b0;
    instr_rdata_op  = '0;
    data_rdata_op   = '0;
    unique case (state_q)
      IDLE: begin
        if (data_req_ip || instr_req_ip) begin
          state_d = REQ;
          owner_d = pick_data;
          if (pick_data) begin
            addr_d  = data_addr_ip;
            we_d    = data_we_ip;
            be_d    = data_be_ip;
            wdata_d = data_wdata_ip;
          end else begin
            addr_d  = instr_addr_ip;
            we_d    = 1'b0;
            be_d    = 4'hF;
            wdata_d = '0;
          end
        end
      end
      REQ: begin
        mem_req_op   = 1'b1;
        mem_addr_op  = addr_q;
        mem_we_op    = we_q;
        mem_be_op    = be_q;
        mem_wdata_op = wdata_q;
        if (mem_gnt_ip) begin
          instr_gnt_op = !owner_q;
          data_gnt_op  = owner_q;
          state_d      = RESP;
          wdog_d       = '0;
        end
      end
      RESP: begin
        if (mem_rvalid_ip) begin
          instr_rvalid_op = !owner_q;
          data_rvalid_op  = owner_q;
          if (owner_q) data_rdata_op  = mem_rdata_ip;
          else         instr_rdata_op = mem_rdata_ip;
          state_d = IDLE;
        end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign timeout_err_op = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

endmodule
